// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB UART register slave and its requester-side arbiter.
package apb_uart_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b11
    } apbState_e;

    localparam logic [3:0] REG_UART_DATA = 4'h0;
    localparam logic [3:0] REG_UART_CTRL = 4'h4;
    localparam logic [3:0] REG_UART_STAT = 4'h8;
    localparam logic [3:0] REG_UART_INT  = 4'hC;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_IE_BIT       = 1;
    localparam int CTRL_CLK_IDX_LSB  = 2;
    localparam int CTRL_CLK_IDX_MSB  = 3;
    localparam int CTRL_BAUD_IDX_LSB = 4;
    localparam int CTRL_BAUD_IDX_MSB = 5;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. The grant is combinational from the requests and
// the remembered last winner; the last winner only moves when the caller
// actually takes the grant, so a grant offered while busy has no effect.
module rr_arb2
    import apb_uart_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_resetN,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_gnt
);

    logic r_lastGrant;

    // Pick the single requester, or on a tie the one that did not win last time.
    always_comb begin
        o_gnt = 2'b00;
        if (i_req[0] && !i_req[1]) begin
            o_gnt = 2'b01;
        end else if (i_req[1] && !i_req[0]) begin
            o_gnt = 2'b10;
        end else if (i_req[0] && i_req[1]) begin
            o_gnt = r_lastGrant ? 2'b01 : 2'b10;
        end
    end

    // Remember the winner; reset to port 1 so port 0 wins the first tie.
    always_ff @(posedge i_clk) begin
        if (!i_resetN) begin
            r_lastGrant <= 1'b1;
        end else if (i_update) begin
            r_lastGrant <= o_gnt[1];
        end
    end

endmodule

// File: rtl/apb_uart_arbiter.sv
// APB master shared by a host port and a DMA/sequencer port. Each granted
// request runs one SETUP/ACCESS transfer; a stalled slave is aborted with an
// error after a bounded number of wait cycles.
module apb_uart_arbiter
    import apb_uart_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  req0_valid,
    input  logic                  req0_write,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  req0_done,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    output logic                  req0_err,
    input  logic                  req1_valid,
    input  logic                  req1_write,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  req1_done,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  req1_err,
    output logic                  busy,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    apbState_e             r_state;
    logic                  r_grantIdx;
    logic                  r_cplIdle;
    logic [15:0]           r_waitCnt;

    logic [1:0]            w_gnt;
    logic                  w_grantFire;
    logic [15:0]           w_waitNext;
    logic                  w_timeout;
    logic                  w_finish;
    logic                  w_cplErr;
    logic [DATA_WIDTH-1:0] w_cplRdata;

    rr_arb2 u_arb (
        .i_clk    (PCLK),
        .i_resetN (PRESETn),
        .i_req    ({req1_valid, req0_valid}),
        .i_update (w_grantFire),
        .o_gnt    (w_gnt)
    );

    // A grant is taken only in an ordinary IDLE cycle, never in the IDLE
    // cycle that reports completion of the previous transfer.
    assign w_grantFire = (r_state == IDLE) && !r_cplIdle && (w_gnt != 2'b00);

    // Wait-state bookkeeping and the completion payload for the ACCESS phase.
    assign w_waitNext = r_waitCnt + 16'd1;
    assign w_timeout  = !PREADY && (TIMEOUT_CYCLES != 0) && (w_waitNext == TIMEOUT_LIM);
    assign w_finish   = PREADY || w_timeout;
    assign w_cplErr   = PREADY ? PSLVERR : 1'b1;
    assign w_cplRdata = (PREADY && !PWRITE) ? PRDATA : '0;

    // Transfer sequencer: every output is a register updated here.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state    <= IDLE;
            r_grantIdx <= 1'b0;
            r_cplIdle  <= 1'b0;
            r_waitCnt  <= '0;
            req0_ready <= 1'b0;
            req0_done  <= 1'b0;
            req0_rdata <= '0;
            req0_err   <= 1'b0;
            req1_ready <= 1'b0;
            req1_done  <= 1'b0;
            req1_rdata <= '0;
            req1_err   <= 1'b0;
            busy       <= 1'b0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
        end else begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cplIdle <= 1'b0;
                    if (w_grantFire) begin
                        r_grantIdx <= w_gnt[1];
                        PWRITE     <= w_gnt[1] ? req1_write : req0_write;
                        PADDR      <= w_gnt[1] ? req1_addr  : req0_addr;
                        PWDATA     <= w_gnt[1] ? req1_wdata : req0_wdata;
                        req0_ready <= w_gnt[0];
                        req1_ready <= w_gnt[1];
                        PSEL       <= 1'b1;
                        busy       <= 1'b1;
                        r_state    <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    r_state <= ACCESS;
                end
                ACCESS: begin
                    if (w_finish) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        busy      <= 1'b0;
                        r_waitCnt <= '0;
                        r_cplIdle <= 1'b1;
                        r_state   <= IDLE;
                        if (r_grantIdx) begin
                            req1_done  <= 1'b1;
                            req1_rdata <= w_cplRdata;
                            req1_err   <= w_cplErr;
                        end else begin
                            req0_done  <= 1'b1;
                            req0_rdata <= w_cplRdata;
                            req0_err   <= w_cplErr;
                        end
                    end else begin
                        r_waitCnt <= w_waitNext;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_uart_arbiter.sv
// Directed bench for apb_uart_arbiter: single writes/reads, tie arbitration,
// wait states, timeout abort, slave error and reset in the middle of ACCESS.
module tb_apb_uart_arbiter;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          PCLK;
    logic          PRESETn;
    logic          req0_valid, req0_write, req0_ready, req0_done, req0_err;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata, req0_rdata;
    logic          req1_valid, req1_write, req1_ready, req1_done, req1_err;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata, req1_rdata;
    logic          busy, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;

    int checks;
    int failures;

    apb_uart_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .req0_valid (req0_valid),
        .req0_write (req0_write),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_ready (req0_ready),
        .req0_done  (req0_done),
        .req0_rdata (req0_rdata),
        .req0_err   (req0_err),
        .req1_valid (req1_valid),
        .req1_write (req1_write),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_ready (req1_ready),
        .req1_done  (req1_done),
        .req1_rdata (req1_rdata),
        .req1_err   (req1_err),
        .busy       (busy),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    // 100 MHz clock.
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic stepCycle();
        @(posedge PCLK);
        #1;
    endtask

    // Drive one requester port.
    task automatic applyStimulus(input int port, input logic valid, input logic write,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (port == 0) begin
            req0_valid = valid; req0_write = write; req0_addr = addr; req0_wdata = wdata;
        end else begin
            req1_valid = valid; req1_write = write; req1_addr = addr; req1_wdata = wdata;
        end
    endtask

    // Drive the slave side of the bus.
    task automatic applySlave(input logic ready, input logic [DW-1:0] rdata, input logic err);
        PREADY = ready; PRDATA = rdata; PSLVERR = err;
    endtask

    // One-cycle synchronous reset pulse.
    task automatic applyReset();
        PRESETn = 1'b0;
        stepCycle();
        PRESETn = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        PRESETn  = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 16'h0);
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 16'h0);
        applySlave(1'b1, 16'h0, 1'b0);

        // Reset state.
        stepCycle();
        stepCycle();
        checkOutput("rst_psel",   PSEL,       0);
        checkOutput("rst_pen",    PENABLE,    0);
        checkOutput("rst_busy",   busy,       0);
        checkOutput("rst_ready",  {req1_ready, req0_ready}, 0);
        checkOutput("rst_done",   {req1_done, req0_done},   0);
        checkOutput("rst_paddr",  PADDR,      0);
        PRESETn = 1'b1;

        // Write CTRL with zero wait states.
        applyStimulus(0, 1'b1, 1'b1, 4'h4, 16'h0034);
        stepCycle();
        checkOutput("t1_setup_psel", PSEL,       1);
        checkOutput("t1_setup_pen",  PENABLE,    0);
        checkOutput("t1_ready0",     req0_ready, 1);
        checkOutput("t1_ready1",     req1_ready, 0);
        checkOutput("t1_busy",       busy,       1);
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 16'h0);
        stepCycle();
        checkOutput("t1_acc_pen",    PENABLE,    1);
        checkOutput("t1_acc_psel",   PSEL,       1);
        checkOutput("t1_pwrite",     PWRITE,     1);
        checkOutput("t1_paddr",      PADDR,      4'h4);
        checkOutput("t1_pwdata",     PWDATA,     16'h0034);
        checkOutput("t1_ready_drop", req0_ready, 0);
        stepCycle();
        checkOutput("t1_done0",      req0_done,  1);
        checkOutput("t1_done1",      req1_done,  0);
        checkOutput("t1_err0",       req0_err,   0);
        checkOutput("t1_rdata0",     req0_rdata, 0);
        checkOutput("t1_idle_psel",  PSEL,       0);
        checkOutput("t1_idle_busy",  busy,       0);
        stepCycle();
        checkOutput("t1_done_pulse", req0_done,  0);

        // Tie between both ports right after reset: port 0 first.
        applyReset();
        applyStimulus(0, 1'b1, 1'b0, 4'h8, 16'h0);
        applyStimulus(1, 1'b1, 1'b0, 4'hC, 16'h0);
        stepCycle();
        checkOutput("t2_ready0",  req0_ready, 1);
        checkOutput("t2_ready1a", req1_ready, 0);
        checkOutput("t2_paddr0",  PADDR,      4'h8);
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 16'h0);
        applySlave(1'b1, 16'h0011, 1'b0);
        stepCycle();
        stepCycle();
        checkOutput("t2_done0",   req0_done,  1);
        checkOutput("t2_done1a",  req1_done,  0);
        checkOutput("t2_rdata0",  req0_rdata, 16'h0011);
        applySlave(1'b1, 16'h0003, 1'b0);
        stepCycle();
        checkOutput("t2_gap_psel",  PSEL,       0);
        checkOutput("t2_gap_ready", req1_ready, 0);
        stepCycle();
        checkOutput("t2_ready1",  req1_ready, 1);
        checkOutput("t2_ready0b", req0_ready, 0);
        checkOutput("t2_paddr1",  PADDR,      4'hC);
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 16'h0);
        stepCycle();
        stepCycle();
        checkOutput("t2_done1",   req1_done,  1);
        checkOutput("t2_done0b",  req0_done,  0);
        checkOutput("t2_rdata1",  req1_rdata, 16'h0003);
        checkOutput("t2_hold0",   req0_rdata, 16'h0011);

        // Port 1 read of DATA with five wait states.
        stepCycle();
        applyStimulus(1, 1'b1, 1'b0, 4'h0, 16'h0);
        applySlave(1'b0, 16'h0000, 1'b0);
        stepCycle();
        checkOutput("t3_ready1", req1_ready, 1);
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 16'h0);
        stepCycle();
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t3_wait_pen%0d", i), PENABLE, 1);
            checkOutput($sformatf("t3_wait_done%0d", i), req1_done, 0);
            stepCycle();
        end
        checkOutput("t3_acc6_pen", PENABLE, 1);
        applySlave(1'b1, 16'h00A5, 1'b0);
        stepCycle();
        checkOutput("t3_done1",  req1_done,  1);
        checkOutput("t3_rdata1", req1_rdata, 16'h00A5);
        checkOutput("t3_err1",   req1_err,   0);
        checkOutput("t3_psel",   PSEL,       0);

        // Timeout: slave stalls a DATA write, abort after eight wait cycles.
        stepCycle();
        applyStimulus(0, 1'b1, 1'b1, 4'h0, 16'h0055);
        applySlave(1'b0, 16'h1234, 1'b0);
        stepCycle();
        checkOutput("t4_ready0", req0_ready, 1);
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 16'h0);
        stepCycle();
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("t4_wait_psel%0d", i), PSEL, 1);
            checkOutput($sformatf("t4_wait_done%0d", i), req0_done, 0);
            stepCycle();
        end
        checkOutput("t4_abort_psel", PSEL,       0);
        checkOutput("t4_abort_pen",  PENABLE,    0);
        checkOutput("t4_done0",      req0_done,  1);
        checkOutput("t4_err0",       req0_err,   1);
        checkOutput("t4_rdata0",     req0_rdata, 0);
        checkOutput("t4_done1",      req1_done,  0);

        // Request raised during the completion cycle waits one more IDLE.
        applyStimulus(1, 1'b1, 1'b0, 4'h4, 16'h0);
        applySlave(1'b1, 16'h0012, 1'b0);
        stepCycle();
        checkOutput("t4_cpl_ready1", req1_ready, 0);
        checkOutput("t4_cpl_psel",   PSEL,       0);
        stepCycle();
        checkOutput("t4_next_ready1", req1_ready, 1);
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 16'h0);
        stepCycle();
        stepCycle();
        checkOutput("t4_next_done1", req1_done,  1);
        checkOutput("t4_next_rdata", req1_rdata, 16'h0012);
        checkOutput("t4_next_err",   req1_err,   0);

        // Slave error on a DATA write.
        stepCycle();
        applyStimulus(0, 1'b1, 1'b1, 4'h0, 16'h0041);
        applySlave(1'b1, 16'h7777, 1'b1);
        stepCycle();
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 16'h0);
        stepCycle();
        stepCycle();
        checkOutput("t5_done0",  req0_done,  1);
        checkOutput("t5_err0",   req0_err,   1);
        checkOutput("t5_rdata0", req0_rdata, 0);
        applySlave(1'b1, 16'h0, 1'b0);

        // Reset during ACCESS with both ports pending afterwards.
        stepCycle();
        applyStimulus(1, 1'b1, 1'b0, 4'h8, 16'h0);
        applySlave(1'b0, 16'h0, 1'b0);
        stepCycle();
        checkOutput("t6_ready1", req1_ready, 1);
        applyStimulus(0, 1'b1, 1'b0, 4'hC, 16'h0);
        stepCycle();
        checkOutput("t6_acc_pen", PENABLE, 1);
        PRESETn = 1'b0;
        applySlave(1'b1, 16'h00EE, 1'b0);
        stepCycle();
        PRESETn = 1'b1;
        checkOutput("t6_rst_psel",  PSEL,       0);
        checkOutput("t6_rst_pen",   PENABLE,    0);
        checkOutput("t6_rst_busy",  busy,       0);
        checkOutput("t6_rst_done",  {req1_done, req0_done}, 0);
        checkOutput("t6_rst_rd1",   req1_rdata, 0);
        checkOutput("t6_rst_paddr", PADDR,      0);
        stepCycle();
        checkOutput("t6_ready0",  req0_ready, 1);
        checkOutput("t6_ready1b", req1_ready, 0);
        checkOutput("t6_paddr",   PADDR,      4'hC);
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 16'h0);
        applySlave(1'b1, 16'h0003, 1'b0);
        stepCycle();
        stepCycle();
        checkOutput("t6_done0",  req0_done,  1);
        checkOutput("t6_rdata0", req0_rdata, 16'h0003);
        checkOutput("t6_done1",  req1_done,  0);
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 16'h0);
        stepCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_uart_arbiter.md
Name: apb_uart_arbiter

Overview:
Two-requester APB master that shares the single UART register slave (DATA 0x0, CTRL 0x4, STAT 0x8, INT 0xC) between a host port and a DMA/sequencer port. Each requester uses a simple valid/ready + done handshake. The block arbitrates round-robin, drives APB SETUP/ACCESS phases and waits on PREADY. It also aborts with an error when the slave stalls too long, for example a DATA write with the TX FIFO full or a DATA read with the RX FIFO empty.

Parameters:
ADDR_WIDTH, 4, APB address width
DATA_WIDTH, 16, APB data width
TIMEOUT_CYCLES, 255, max ACCESS wait cycles with PREADY=0 before abort; 0 disables timeout (max 65535)

Ports:
PCLK  in  1  clock
PRESETn  in  1  reset; synchronous, active-low
req0_valid / req1_valid  in  1  request pending; held until reqN_ready
req0_write / req1_write  in  1  1=write, 0=read
req0_addr / req1_addr  in  ADDR_WIDTH  register address
req0_wdata / req1_wdata  in  DATA_WIDTH  write data
req0_ready / req1_ready  out  1  one-cycle accept pulse; request fields captured
req0_done / req1_done  out  1  one-cycle completion pulse
req0_rdata / req1_rdata  out  DATA_WIDTH  read data, valid with done; held until next done on that port
req0_err / req1_err  out  1  PSLVERR or timeout, valid with done
busy  out  1  high in SETUP/ACCESS
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_WIDTH  APB address
PWDATA  out  DATA_WIDTH  APB write data
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error

Behaviour:
- Reset is synchronous, active-low, sampled on the PCLK rising edge.
- Reset values: all outputs 0; FSM=IDLE; last_grant=1, so req0 wins first; timeout counter=0.
- FSM states: IDLE -> SETUP -> ACCESS -> IDLE. All outputs are registered.
- IDLE:
  - Any valid: grant the winner, latch write/addr/wdata into PWRITE/PADDR/PWDATA, go to SETUP.
  - The winner's ready pulse is asserted in the SETUP cycle. The requester may change its fields from the next cycle.
- Arbitration:
  - Only one valid: that requester wins.
  - Both valid: the requester != last_grant wins.
  - last_grant is updated at grant.
  - The loser keeps valid high and is served next transfer, so there is no starvation.
- SETUP (1 cycle): PSEL=1, PENABLE=0. Unconditionally go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA stable.
  - PREADY=1: capture PRDATA (reads only; writes return rdata=0) and PSLVERR. Pulse the granted done next cycle with rdata/err. Go to IDLE. PSEL and PENABLE are 0 in that IDLE cycle.
  - PREADY=0: increment the counter. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES, abort: go to IDLE, done with err=1, rdata=0, PSEL dropped.
  - Counter clears on leaving ACCESS.
- Minimum transfer is 3 cycles: SETUP, ACCESS, IDLE. A mandatory IDLE cycle separates back-to-back transfers. New requests are never granted in the completion IDLE cycle; they are granted in the following IDLE.
- Latency: valid in IDLE -> done at the earliest 3 cycles later.
- valid deasserted before ready: the request is dropped only if seen in IDLE before grant. After grant, the transfer completes regardless.
- The non-granted port never sees ready, done or err pulses.
- Reset mid-transfer: immediately IDLE, PSEL/PENABLE=0, no done pulse, captured data discarded.
- PSLVERR is sampled only when PREADY=1 in ACCESS.

Decomposition:
- Shared package apb_uart_pkg:
  - FSM encoding IDLE=2'b00, SETUP=2'b01, ACCESS=2'b11
  - register offsets REG_UART_DATA/CTRL/STAT/INT = 0x0/0x4/0x8/0xC
  - CTRL field positions: en[0], IE[1], clk_freq_index[3:2], baud_rate_index[5:4]
- One sub-module, rr_arb2: 2-way round-robin grant with last_grant register and update-on-grant input.

Test Plan:
- req0 write addr 0x4 data 0x0034, PREADY=1 on first ACCESS -> PSEL on cycles 1-2, PENABLE on cycle 2, PWDATA=0x0034; req0_done at cycle 3, err=0.
- req0 and req1 valid in the same cycle (reads of 0x8 and 0xC) -> req0 granted first, req1 next after one IDLE; second done pulses req1_done only; rdata matches PRDATA values 0x0011 and 0x0003.
- req1 read 0x0 with PREADY held low 5 ACCESS cycles, then PRDATA=0x00A5 with PREADY=1 -> ACCESS lasts 6 cycles, req1_rdata=0x00A5, err=0.
- TIMEOUT_CYCLES=8, PREADY stuck 0 -> abort after 8 wait cycles, PSEL drops, done with err=1, rdata=0; next request served normally.
- PSLVERR=1 with PREADY=1 on a write to 0x0 -> done with err=1.
- PRESETn low for 1 cycle during ACCESS -> next cycle all outputs 0, no done; pending valid then granted starting with req0.
